// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state encoding, opcodes and datapath select encodings for the multi-cycle control FSM
package mc_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_e;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [1:0] A_PC      = 2'b00;
  localparam logic [1:0] A_OLDPC   = 2'b01;
  localparam logic [1:0] A_RS1     = 2'b10;
  localparam logic [1:0] B_RS2     = 2'b00;
  localparam logic [1:0] B_IMM     = 2'b01;
  localparam logic [1:0] B_FOUR    = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
endpackage

// File: rtl/mc_main_fsm.sv
// mc_main_fsm: main control FSM of the multi-cycle RV32I core with retired-instruction counter
module mc_main_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W           = 32,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_op,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             illegal,
  output logic [3:0]       state
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] instret_q;
  logic illegal_q;
  logic req_c, wr_c, ir_c, pc_c, rw_c, ret_c;
  always_comb begin
    state_d    = state_q;
    req_c      = 1'b0;
    wr_c       = 1'b0;
    ir_c       = 1'b0;
    pc_c       = 1'b0;
    rw_c       = 1'b0;
    ret_c      = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = A_PC;
    alu_src_b  = B_RS2;
    result_src = RES_ALUOUT;
    alu_op     = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        req_c      = 1'b1;
        alu_src_b  = B_FOUR;
        result_src = RES_ALU;
        ir_c       = mem_ready;
        pc_c       = mem_ready;
        state_d    = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a = A_OLDPC;
        alu_src_b = B_IMM;
        if (op == OP_LOAD || op == OP_STORE) state_d = S_MEMADR;
        else if (op == OP_R) state_d = S_EXECR;
        else if (op == OP_I) state_d = S_EXECI;
        else if (op == OP_BRANCH && funct3[2:1] == 2'b00) state_d = S_BRANCH;
        else if (op == OP_JAL) state_d = S_JAL;
        else if (TRAP_ON_ILLEGAL) state_d = S_TRAP;
        else begin
          ret_c   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEMADR: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        state_d   = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        req_c   = 1'b1;
        adr_src = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        rw_c       = 1'b1;
        ret_c      = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        req_c   = 1'b1;
        wr_c    = 1'b1;
        adr_src = 1'b1;
        ret_c   = mem_ready;
        state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        alu_src_a = A_RS1;
        alu_op    = ALU_FUNCT;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        alu_op    = ALU_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        rw_c    = 1'b1;
        ret_c   = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = A_RS1;
        alu_op    = ALU_SUB;
        pc_c      = zero ^ funct3[0];
        ret_c     = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = A_OLDPC;
        alu_src_b = B_FOUR;
        pc_c      = 1'b1;
        state_d   = S_ALUWB;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ret_c) instret_q <= instret_q + CNT_W'(1);
      if (state_d == S_TRAP) illegal_q <= 1'b1;
    end
  end
  // strobes are masked combinationally so an asserted reset kills them without waiting for a clock
  assign mem_req   = req_c & rst_n;
  assign mem_write = wr_c & rst_n;
  assign ir_write  = ir_c & rst_n;
  assign pc_write  = pc_c & rst_n;
  assign reg_write = rw_c & rst_n;
  assign retire    = ret_c & rst_n;
  assign instret   = instret_q;
  assign illegal   = illegal_q;
  assign state     = state_q;
endmodule

// File: tb/tb_mc_main_fsm.sv
// tb_mc_main_fsm: randomized check of two mc_main_fsm configurations against an instruction-path model
module tb_mc_main_fsm;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n[2], zero[2], mem_ready[2];
  logic [6:0] op[2];
  logic [2:0] funct3[2];
  logic mem_req[2], mem_write[2], adr_src[2], ir_write[2], pc_write[2], reg_write[2], retire[2], illegal[2];
  logic [1:0] alu_src_a[2], alu_src_b[2], result_src[2], alu_op[2];
  logic [3:0] state[2];
  logic [31:0] instret0;
  logic [3:0] instret1;
  int path[2][8];
  int plen[2], idx[2], rst_hold[2], trap_cnt[2];
  logic [31:0] m_ret[2];
  int checks = 0, errors = 0, cyc = 0;

  mc_main_fsm #(.CNT_W(32), .TRAP_ON_ILLEGAL(1'b1)) d0 (
    .clk(clk), .rst_n(rst_n[0]), .op(op[0]), .funct3(funct3[0]), .zero(zero[0]), .mem_ready(mem_ready[0]),
    .mem_req(mem_req[0]), .mem_write(mem_write[0]), .adr_src(adr_src[0]), .ir_write(ir_write[0]),
    .pc_write(pc_write[0]), .reg_write(reg_write[0]), .alu_src_a(alu_src_a[0]), .alu_src_b(alu_src_b[0]),
    .result_src(result_src[0]), .alu_op(alu_op[0]), .retire(retire[0]), .instret(instret0),
    .illegal(illegal[0]), .state(state[0]));
  mc_main_fsm #(.CNT_W(4), .TRAP_ON_ILLEGAL(1'b0)) d1 (
    .clk(clk), .rst_n(rst_n[1]), .op(op[1]), .funct3(funct3[1]), .zero(zero[1]), .mem_ready(mem_ready[1]),
    .mem_req(mem_req[1]), .mem_write(mem_write[1]), .adr_src(adr_src[1]), .ir_write(ir_write[1]),
    .pc_write(pc_write[1]), .reg_write(reg_write[1]), .alu_src_a(alu_src_a[1]), .alu_src_b(alu_src_b[1]),
    .result_src(result_src[1]), .alu_op(alu_op[1]), .retire(retire[1]), .instret(instret1),
    .illegal(illegal[1]), .state(state[1]));

  // The whole phase sequence of an instruction is known once its opcode is chosen.
  task automatic build(input int k);
    path[k][0] = 0;
    path[k][1] = 1;
    case (op[k])
      7'b0000011: begin path[k][2] = 2; path[k][3] = 3; path[k][4] = 4; plen[k] = 5; end
      7'b0100011: begin path[k][2] = 2; path[k][3] = 5; plen[k] = 4; end
      7'b0110011: begin path[k][2] = 6; path[k][3] = 8; plen[k] = 4; end
      7'b0010011: begin path[k][2] = 7; path[k][3] = 8; plen[k] = 4; end
      7'b1101111: begin path[k][2] = 10; path[k][3] = 8; plen[k] = 4; end
      default: begin
        if (op[k] == 7'b1100011 && funct3[k] < 3'd2) begin path[k][2] = 9; plen[k] = 3; end
        else if (k == 0) begin path[k][2] = 11; plen[k] = 3; end
        else plen[k] = 2;
      end
    endcase
  endtask

  function automatic logic advances(input int k);
    int s = path[k][idx[k]];
    if (s == 11) return 1'b0;
    if (s == 0 || s == 3 || s == 5) return mem_ready[k];
    return 1'b1;
  endfunction

  task automatic exp_out(input int k, output logic [18:0] v, output logic r);
    int s = rst_n[k] ? path[k][idx[k]] : 0;
    logic req = 0, wr = 0, adr = 0, ir = 0, pc = 0, rw = 0, ill = 0;
    logic [1:0] a = 0, b = 0, rs = 0, aop = 0;
    case (s)
      0: begin req = 1; ir = mem_ready[k]; pc = mem_ready[k]; b = 2; rs = 2; end
      1: begin a = 1; b = 1; end
      2: begin a = 2; b = 1; end
      3: begin req = 1; adr = 1; end
      4: begin rs = 1; rw = 1; end
      5: begin req = 1; wr = 1; adr = 1; end
      6: begin a = 2; aop = 2; end
      7: begin a = 2; b = 1; aop = 2; end
      8: rw = 1;
      9: begin a = 2; aop = 1; pc = zero[k] ^ funct3[k][0]; end
      10: begin a = 1; b = 2; pc = 1; end
      default: ill = 1;
    endcase
    if (!rst_n[k]) begin req = 0; ir = 0; pc = 0; end
    v = {req, wr, adr, ir, pc, rw, a, b, rs, aop, ill, s[3:0]};
    r = rst_n[k] && advances(k) && idx[k] == plen[k] - 1 && s != 11;
  endtask

  task automatic check(input int k);
    logic [18:0] ev, dv;
    logic er;
    logic [31:0] gi, ei;
    exp_out(k, ev, er);
    dv = {mem_req[k], mem_write[k], adr_src[k], ir_write[k], pc_write[k], reg_write[k],
          alu_src_a[k], alu_src_b[k], result_src[k], alu_op[k], illegal[k], state[k]};
    gi = (k == 0) ? instret0 : {28'b0, instret1};
    ei = rst_n[k] ? m_ret[k] : 32'd0;
    checks += 3;
    if (dv !== ev) begin errors++; $display("FAIL d%0d outputs cyc %0d: got %h expected %h", k, cyc, dv, ev); end
    if (retire[k] !== er) begin errors++; $display("FAIL d%0d retire cyc %0d: got %b expected %b", k, cyc, retire[k], er); end
    if (gi !== ei) begin errors++; $display("FAIL d%0d instret cyc %0d: got %0d expected %0d", k, cyc, gi, ei); end
  endtask

  task automatic lit(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin errors++; $display("FAIL %s: got %0d expected %0d", name, got, expv); end
  endtask

  task automatic drive(input int k);
    int r;
    zero[k] = 1'($urandom % 2);
    if (cyc < 4) begin
      rst_n[k] = 1'b1;
      mem_ready[k] = 1'b1;
      if (idx[k] == 0) begin op[k] = 7'b0110011; funct3[k] = 3'd0; build(k); end
      return;
    end
    if (rst_hold[k] > 0) begin rst_n[k] = 1'b0; rst_hold[k]--; end
    else rst_n[k] = 1'b1;
    if (rst_n[k] && ((path[k][idx[k]] == 5 && $urandom % 4 == 0) || $urandom % 300 == 0 || trap_cnt[k] >= 20)) begin
      rst_n[k] = 1'b0;
      rst_hold[k] = $urandom % 2;
      trap_cnt[k] = 0;
    end
    mem_ready[k] = 1'($urandom % 2);
    if (idx[k] == 0) begin
      r = $urandom % 10;
      funct3[k] = 3'($urandom % 8);
      op[k] = (r == 0) ? 7'b0000011 : (r == 1) ? 7'b0100011 : (r == 2 || r == 8) ? 7'b0110011 :
              (r == 3) ? 7'b0010011 : (r == 4 || r == 6) ? 7'b1100011 : (r == 5) ? 7'b1101111 :
              (r == 7) ? 7'b1111111 : 7'($urandom);
      build(k);
    end
  endtask

  task automatic step(input int k);
    int s;
    if (!rst_n[k]) begin
      idx[k] = 0;
      m_ret[k] = 0;
      return;
    end
    s = path[k][idx[k]];
    if (s == 11) trap_cnt[k]++;
    if (advances(k)) begin
      if (idx[k] == plen[k] - 1) begin
        m_ret[k] = (m_ret[k] + 1) & ((k == 0) ? 32'hFFFF_FFFF : 32'hF);
        idx[k] = 0;
      end else idx[k]++;
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; mem_ready[k] = 1'b1; zero[k] = 1'b0; op[k] = '0; funct3[k] = '0;
      idx[k] = 0; m_ret[k] = 0; rst_hold[k] = 0; trap_cnt[k] = 0; plen[k] = 2;
      path[k][0] = 0;
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    lit("reset state", int'(state[0]), 0);
    lit("reset instret", int'(instret0), 0);
    lit("reset mem_req", int'(mem_req[0]), 0);
    lit("reset ir_write", int'(ir_write[0]), 0);
    lit("reset alu_src_b", int'(alu_src_b[0]), 2);
    for (cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) drive(k);
      #1;
      for (int k = 0; k < 2; k++) check(k);
      case (cyc)
        0: begin lit("rtype fetch state", int'(state[0]), 0); lit("rtype fetch ir_write", int'(ir_write[0]), 1);
                 lit("rtype fetch pc_write", int'(pc_write[0]), 1); end
        1: lit("rtype decode state", int'(state[0]), 1);
        2: begin lit("rtype execr state", int'(state[0]), 6); lit("rtype execr alu_op", int'(alu_op[0]), 2);
                 lit("rtype execr alu_src_a", int'(alu_src_a[0]), 2); end
        3: begin lit("rtype aluwb state", int'(state[0]), 8); lit("rtype aluwb reg_write", int'(reg_write[0]), 1);
                 lit("rtype aluwb retire", int'(retire[0]), 1); end
        4: lit("rtype instret", int'(instret0), 1);
        default: ;
      endcase
      @(posedge clk);
      for (int k = 0; k < 2; k++) step(k);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
